btb_predictor: RTL and testbench
================================

// Module: btb_predictor
// PURPOSE
//  Parametrised branch target buffer with per-entry saturating direction counters, for the fetch stage.
//  Fetch presents the current PC and gets a same-cycle next-PC prediction: taken target or PC+1.
//  The resolving stage (EX) writes back the outcome and the PC-relative offset one port per cycle.
//  Adds valid bits, an N-bit hysteresis counter, allocate-on-taken only, and deterministic victim selection.
// PARAMETERS
//  PC_W      16          PC and offset width (bits)
//  DEPTH     8           number of entries; power of 2, >=2
//  IDX_W     $clog2(DEPTH)  entry index / replacement pointer width
//  CTR_W     2           direction counter width; predict taken when MSB=1
//  CTR_ALLOC 2'b10       counter value written on allocation (weakly taken)
// PORTS
//  clk          in   1      clock; all state updates on posedge
//  clr          in   1      synchronous active-high reset; clears all valid bits, counters, pointer
//  lookup_pc    in   PC_W   fetch PC to predict
//  pred_hit     out  1      valid entry with tag==lookup_pc exists
//  pred_taken   out  1      pred_hit & ctr[CTR_W-1]
//  pred_target  out  PC_W   pred_taken ? lookup_pc+offset : lookup_pc+1
//  upd_en       in   1      resolve-stage update strobe
//  upd_pc       in   PC_W   PC of the resolved branch
//  upd_offset   in   PC_W   PC-relative target offset of that branch
//  upd_taken    in   1      actual outcome
//  occupancy    out  IDX_W+1  count of valid entries (0..DEPTH)
// BEHAVIOUR
//  Lookup: purely combinational from current table state, zero latency. Tag compare is full PC_W bits.
//   Entries are unique by construction; no multi-hit case exists.
//  After clr: pred_hit=0, pred_taken=0, pred_target=lookup_pc+1, occupancy=0, victim ptr=0.
//  Arithmetic: targets are modulo 2^PC_W (wrap silently); occupancy never exceeds DEPTH.
//  Update (posedge, upd_en=1, clr=0):
//   hit on upd_pc, taken     -> ctr = sat_inc(ctr); offset <= upd_offset
//   hit on upd_pc, not taken -> ctr = sat_dec(ctr); offset unchanged
//   miss, not taken          -> no change (no allocation)
//   miss, taken              -> allocate: tag<=upd_pc, offset<=upd_offset, ctr<=CTR_ALLOC, valid<=1
//  Counters saturate at 0 and 2^CTR_W-1; never wrap.
//  Victim selection on allocate: lowest-index invalid entry if any (occupancy increments);
//   else entry at round-robin ptr, ptr <= ptr+1 mod DEPTH (occupancy unchanged).
//   ptr advances only when used for replacement.
//  Simultaneous lookup and update of the same PC in one cycle: lookup returns pre-update state
//   (no bypass); the new state is visible the following cycle.
//  clr and upd_en in same cycle: clr wins, update dropped.
//  upd_en=0: table, ptr, occupancy hold.
//  No X on outputs after first clr, even with lookup_pc unknown-free.
// STRUCTURE
//  Package btb_pkg: CTR_W-generic sat_inc/sat_dec functions, CTR_ALLOC, and the entry struct/field layout:
//   {valid, tag[PC_W], offset[PC_W], ctr[CTR_W]}.
//  Sub-module btb_victim_sel: combinational. valid vector + rr ptr -> victim index, uses_ptr flag.
//   Implemented as a lowest-index-first priority encoder.
//  Top: entry storage array, hit compare/select, update logic, occupancy counter.
// TESTING
//  1 clr; lookup_pc=0x0040 -> hit=0, taken=0, target=0x0041, occupancy=0.
//  2 upd pc=0x0040 off=0x0010 taken=1 -> next cycle lookup 0x0040: hit=1, taken=1, target=0x0050, occupancy=1.
//  3 Counter hysteresis, pc 0x0040: two not-taken updates -> ctr 10->01->00, taken=0, target=0x0041.
//    Three taken updates -> 01, 10 (taken=1), 11, then saturates at 11.
//  4 Not-taken update to unknown pc 0x0100 -> no allocation, occupancy unchanged, lookup hit=0.
//  5 Fill DEPTH=8 with pcs 0x10..0x17, then allocate 0x20, 0x21 -> replace idx0 then idx1.
//    Lookup 0x10 misses, 0x12 hits, occupancy stays 8.
//  6 Wrap and corners: pc=0xFFF0 off=0x0020 taken -> target 0x0010.
//    Same-cycle lookup+update of 0x0040 shows old state.
//    clr with upd_en=1 -> table empty next cycle.

Source files
------------

// File: rtl/btb_pkg.sv
// Shared types and counter helpers for the branch target buffer.
// The entry layout is {valid, tag, offset, ctr}; counters saturate and never wrap.
package btb_pkg;

  localparam int PC_W  = 16;
  localparam int CTR_W = 2;

  localparam logic [CTR_W-1:0] CTR_MAX   = '1;
  localparam logic [CTR_W-1:0] CTR_ALLOC = {1'b1, {(CTR_W-1){1'b0}}};

  typedef struct packed {
    logic             valid;
    logic [PC_W-1:0]  tag;
    logic [PC_W-1:0]  offset;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  function automatic logic [CTR_W-1:0] sat_inc(input logic [CTR_W-1:0] c);
    return (c == CTR_MAX) ? c : c + CTR_W'(1);
  endfunction

  function automatic logic [CTR_W-1:0] sat_dec(input logic [CTR_W-1:0] c);
    return (c == '0) ? c : c - CTR_W'(1);
  endfunction

endpackage

// File: rtl/btb_victim_sel.sv
// Allocation victim choice: lowest-index invalid entry, otherwise the round-robin pointer.
// uses_ptr tells the caller the pointer was consumed and must advance.
module btb_victim_sel #(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0] valid,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] victim_idx,
  output logic             uses_ptr
);

  // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
  always_comb begin
    victim_idx = ptr;
    uses_ptr   = 1'b1;
    // Scanning downwards lets the lowest invalid index win.
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        victim_idx = IDX_W'(i);
        uses_ptr   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/btb_predictor.sv
// Fetch-stage branch target buffer: same-cycle next-PC prediction from a small fully
// associative table, trained one resolved branch per cycle from the execute stage.
module btb_predictor
  import btb_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [PC_W-1:0]  lookup_pc,
  output logic             pred_hit,
  output logic             pred_taken,
  output logic [PC_W-1:0]  pred_target,
  input  logic             upd_en,
  input  logic [PC_W-1:0]  upd_pc,
  input  logic [PC_W-1:0]  upd_offset,
  input  logic             upd_taken,
  output logic [IDX_W:0]   occupancy
);

  localparam int OCC_W = IDX_W + 1;

  btb_entry_t       table_q [DEPTH];
  btb_entry_t       table_d [DEPTH];
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;

  logic [DEPTH-1:0] valid_vec;
  logic [IDX_W-1:0] victim_idx;
  logic             victim_uses_ptr;

  logic             upd_hit;
  logic [IDX_W-1:0] upd_idx;
  logic [PC_W-1:0]  hit_offset;
  logic [CTR_W-1:0] hit_ctr;

  // Lookup reads only registered state, so a same-cycle update is not bypassed.
  always_comb begin
    pred_hit   = 1'b0;
    hit_offset = '0;
    hit_ctr    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (table_q[i].valid && table_q[i].tag == lookup_pc) begin
        pred_hit   = 1'b1;
        hit_offset = table_q[i].offset;
        hit_ctr    = table_q[i].ctr;
      end
    end
  end

  assign pred_taken  = pred_hit & hit_ctr[CTR_W-1];
  assign pred_target = pred_taken ? lookup_pc + hit_offset : lookup_pc + PC_W'(1);
  assign occupancy   = occ_q;

  always_comb begin
    valid_vec = '0;
    upd_hit   = 1'b0;
    upd_idx   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_vec[i] = table_q[i].valid;
      if (table_q[i].valid && table_q[i].tag == upd_pc) begin
        upd_hit = 1'b1;
        upd_idx = IDX_W'(i);
      end
    end
  end

  btb_victim_sel #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_victim_sel (
    .valid      (valid_vec),
    .ptr        (ptr_q),
    .victim_idx (victim_idx),
    .uses_ptr   (victim_uses_ptr)
  );

  // NOTE: next-state logic uses blocking '=' so later statements see earlier field updates.
  always_comb begin
    table_d = table_q;
    ptr_d   = ptr_q;
    occ_d   = occ_q;
    if (upd_en) begin
      if (upd_hit) begin
        if (upd_taken) begin
          table_d[upd_idx].ctr    = sat_inc(table_q[upd_idx].ctr);
          table_d[upd_idx].offset = upd_offset;
        end else begin
          table_d[upd_idx].ctr    = sat_dec(table_q[upd_idx].ctr);
        end
      end else if (upd_taken) begin
        table_d[victim_idx] = '{valid: 1'b1, tag: upd_pc, offset: upd_offset, ctr: CTR_ALLOC};
        // Replacing a live entry keeps occupancy; filling a hole grows it.
        if (victim_uses_ptr) ptr_d = ptr_q + IDX_W'(1);
        else                 occ_d = occ_q + OCC_W'(1);
      end
    end
  end

  // NOTE: the table is flops, not a RAM macro, so clearing every field on clr keeps outputs X-free.
  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      ptr_q <= '0;
      occ_q <= '0;
    end else begin
      // NOTE: state registers take non-blocking '<=' so every flop samples pre-edge values.
      table_q <= table_d;
      ptr_q   <= ptr_d;
      occ_q   <= occ_d;
    end
  end

endmodule

// File: tb/tb_btb_predictor.sv
// Bench for btb_predictor: directed vector table, hand-written replacement/clear sequences,
// and a randomized run compared against an array-based behavioural model.
module tb_btb_predictor;
  import btb_pkg::*;

  localparam int DEPTH = 8;
  localparam int IDX_W = 3;

  logic              clk = 1'b0;
  logic              clr;
  logic [PC_W-1:0]   lookup_pc;
  logic              pred_hit;
  logic              pred_taken;
  logic [PC_W-1:0]   pred_target;
  logic              upd_en;
  logic [PC_W-1:0]   upd_pc;
  logic [PC_W-1:0]   upd_offset;
  logic              upd_taken;
  logic [IDX_W:0]    occupancy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btb_predictor #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
    .clk         (clk),
    .clr         (clr),
    .lookup_pc   (lookup_pc),
    .pred_hit    (pred_hit),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (upd_en),
    .upd_pc      (upd_pc),
    .upd_offset  (upd_offset),
    .upd_taken   (upd_taken),
    .occupancy   (occupancy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: plain arrays, integer counters, occupancy derived by counting.
  localparam int M_MAX   = (1 << CTR_W) - 1;
  localparam int M_THRES = 1 << (CTR_W - 1);
  bit m_valid [DEPTH];
  int m_tag   [DEPTH];
  int m_off   [DEPTH];
  int m_ctr   [DEPTH];
  int m_ptr;

  function automatic void m_clear();
    for (int i = 0; i < DEPTH; i++) begin
      m_valid[i] = 1'b0; m_tag[i] = 0; m_off[i] = 0; m_ctr[i] = 0;
    end
    m_ptr = 0;
  endfunction

  function automatic int m_find(input int pc);
    for (int i = 0; i < DEPTH; i++)
      if (m_valid[i] && m_tag[i] == pc) return i;
    return -1;
  endfunction

  function automatic int m_occ();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) if (m_valid[i]) n++;
    return n;
  endfunction

  function automatic void m_update(input int pc, input int off, input bit taken);
    int i = m_find(pc);
    int v = -1;
    if (i >= 0) begin
      if (taken) begin
        m_ctr[i] = (m_ctr[i] < M_MAX) ? m_ctr[i] + 1 : M_MAX;
        m_off[i] = off;
      end else begin
        m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
      end
    end else if (taken) begin
      for (int j = 0; j < DEPTH; j++) if (!m_valid[j] && v < 0) v = j;
      if (v < 0) begin
        v = m_ptr;
        m_ptr = (m_ptr + 1) % DEPTH;
      end
      m_valid[v] = 1'b1; m_tag[v] = pc; m_off[v] = off; m_ctr[v] = M_THRES;
    end
  endfunction

  task automatic check_model(input int cyc);
    int  i = m_find(int'(lookup_pc));
    bit  e_hit = (i >= 0);
    bit  e_taken = e_hit && (m_ctr[i] >= M_THRES);
    int  e_tgt = e_taken ? (int'(lookup_pc) + m_off[i]) & 16'hFFFF : (int'(lookup_pc) + 1) & 16'hFFFF;
    check($sformatf("rnd%0d hit", cyc),    32'(pred_hit),    32'(e_hit));
    check($sformatf("rnd%0d taken", cyc),  32'(pred_taken),  32'(e_taken));
    check($sformatf("rnd%0d target", cyc), 32'(pred_target), 32'(e_tgt));
    check($sformatf("rnd%0d occ", cyc),    32'(occupancy),   32'(m_occ()));
  endtask

  typedef struct {
    bit          en;
    logic [15:0] pc;
    logic [15:0] off;
    bit          tk;
    logic [15:0] lk;
    bit          hit;
    bit          taken;
    logic [15:0] tgt;
    int          occ;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input bit en, input logic [15:0] pc, input logic [15:0] off,
                              input bit tk, input logic [15:0] lk, input bit hit,
                              input bit taken, input logic [15:0] tgt, input int occ);
    vec_t v;
    v.en = en; v.pc = pc; v.off = off; v.tk = tk; v.lk = lk;
    v.hit = hit; v.taken = taken; v.tgt = tgt; v.occ = occ;
    return v;
  endfunction

  initial begin
    clr = 1'b1; upd_en = 1'b0; upd_pc = '0; upd_offset = '0; upd_taken = 1'b0;
    lookup_pc = 16'h0040;
    tick();
    clr = 1'b0;

    // Outputs are checked just before the edge, so each row shows state prior to its own update.
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0040, 0, 0, 16'h0041, 0));
    vecs.push_back(mk(1, 16'h0040, 16'h0010, 1, 16'h0040, 0, 0, 16'h0041, 0));
    vecs.push_back(mk(1, 16'h0040, 16'h0000, 0, 16'h0040, 1, 1, 16'h0050, 1));
    vecs.push_back(mk(1, 16'h0040, 16'h0000, 0, 16'h0040, 1, 0, 16'h0041, 1));
    vecs.push_back(mk(1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 0, 16'h0041, 1));
    vecs.push_back(mk(1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 0, 16'h0041, 1));
    vecs.push_back(mk(1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 1, 16'h0050, 1));
    vecs.push_back(mk(1, 16'h0040, 16'h0010, 1, 16'h0040, 1, 1, 16'h0050, 1));
    vecs.push_back(mk(1, 16'h0040, 16'h0000, 0, 16'h0040, 1, 1, 16'h0050, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0040, 1, 1, 16'h0050, 1));
    vecs.push_back(mk(1, 16'h0100, 16'h0008, 0, 16'h0100, 0, 0, 16'h0101, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0100, 0, 0, 16'h0101, 1));
    vecs.push_back(mk(1, 16'hFFF0, 16'h0020, 1, 16'hFFF0, 0, 0, 16'hFFF1, 1));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'hFFF0, 1, 1, 16'h0010, 2));
    vecs.push_back(mk(1, 16'h0040, 16'h0030, 1, 16'h0040, 1, 1, 16'h0050, 2));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'h0040, 1, 1, 16'h0070, 2));
    vecs.push_back(mk(0, 16'h0000, 16'h0000, 0, 16'hFFFF, 0, 0, 16'h0000, 2));

    foreach (vecs[k]) begin
      upd_en = vecs[k].en; upd_pc = vecs[k].pc; upd_offset = vecs[k].off;
      upd_taken = vecs[k].tk; lookup_pc = vecs[k].lk;
      #3;
      check($sformatf("vec%0d hit", k),    32'(pred_hit),    32'(vecs[k].hit));
      check($sformatf("vec%0d taken", k),  32'(pred_taken),  32'(vecs[k].taken));
      check($sformatf("vec%0d target", k), 32'(pred_target), 32'(vecs[k].tgt));
      check($sformatf("vec%0d occ", k),    32'(occupancy),   32'(vecs[k].occ));
      tick();
    end
    upd_en = 1'b0;

    // Fill all entries, then two allocations must replace idx0 and idx1 in turn.
    clr = 1'b1; tick(); clr = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      upd_en = 1'b1; upd_pc = 16'h0010 + 16'(i); upd_offset = 16'h0100; upd_taken = 1'b1;
      tick();
    end
    upd_en = 1'b0; lookup_pc = 16'h0017; #1;
    check("fill occ", 32'(occupancy), 32'd8);
    check("fill hit17", 32'(pred_hit), 32'd1);
    upd_en = 1'b1; upd_pc = 16'h0020; upd_offset = 16'h0200; tick();
    upd_pc = 16'h0021; tick();
    upd_en = 1'b0;
    lookup_pc = 16'h0010; #1; check("repl miss10", 32'(pred_hit), 32'd0);
    lookup_pc = 16'h0011; #1; check("repl miss11", 32'(pred_hit), 32'd0);
    lookup_pc = 16'h0012; #1; check("repl hit12", 32'(pred_hit), 32'd1);
    check("repl tgt12", 32'(pred_target), 32'h0112);
    lookup_pc = 16'h0021; #1; check("repl tgt21", 32'(pred_target), 32'h0221);
    check("repl occ", 32'(occupancy), 32'd8);
    upd_en = 1'b1; upd_pc = 16'h0022; tick();
    upd_en = 1'b0;
    lookup_pc = 16'h0012; #1; check("repl miss12", 32'(pred_hit), 32'd0);
    lookup_pc = 16'h0013; #1; check("repl hit13", 32'(pred_hit), 32'd1);

    // clr wins over a simultaneous allocation.
    clr = 1'b1; upd_en = 1'b1; upd_pc = 16'h0033; upd_offset = 16'h0004; upd_taken = 1'b1;
    tick();
    clr = 1'b0; upd_en = 1'b0;
    lookup_pc = 16'h0033; #1;
    check("clr+upd hit33", 32'(pred_hit), 32'd0);
    check("clr+upd tgt33", 32'(pred_target), 32'h0034);
    lookup_pc = 16'h0013; #1; check("clr+upd hit13", 32'(pred_hit), 32'd0);
    check("clr+upd occ", 32'(occupancy), 32'd0);

    // Randomized run: 12 PCs compete for 8 entries, with occasional clr.
    m_clear();
    for (int c = 0; c < 600; c++) begin
      bit do_clr = ($urandom_range(0, 49) == 0);
      clr        = do_clr;
      upd_en     = ($urandom_range(0, 3) != 0);
      upd_pc     = 16'h0200 + 16'($urandom_range(0, 11));
      upd_offset = 16'($urandom);
      upd_taken  = ($urandom_range(0, 2) != 0);
      lookup_pc  = ($urandom_range(0, 3) == 0) ? upd_pc : 16'h0200 + 16'($urandom_range(0, 11));
      #3;
      check_model(c);
      @(posedge clk);
      if (do_clr) m_clear();
      else if (upd_en) m_update(int'(upd_pc), int'(upd_offset), upd_taken);
      #1;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
